// File: rtl/mealy_seq_ctrl.sv
// mealy_seq_ctrl: drives a 1-in/1-out Mealy FSM as a shared test resource.
// On start it resets the FSM, then streams a pattern into x one bit per
// clock while sampling z, and reports a hit map, hit count and first hit.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : run request (sampled only in IDLE)
//   pattern, len   : bits to stream and count (len clamps to W)
//   busy, done     : busy in CLR/SHIFT; done is a one-cycle pulse
//   fsm_rst, fsm_x : reset and x input driven into the controlled FSM
//   fsm_z          : combinational Mealy output of the controlled FSM
//   hit_map        : bit i = z sampled while pattern index i was presented
//   hit_count      : number of hits
//   first_hit_idx  : index of first hit, W when there was none
//   any_hit        : hit_count != 0
module mealy_seq_ctrl #(
    parameter int W         = 8,
    parameter int MSB_FIRST = 0,
    parameter int CW        = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [CW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          fsm_rst,
    output logic          fsm_x,
    input  logic          fsm_z,
    output logic [W-1:0]  hit_map,
    output logic [CW-1:0] hit_count,
    output logic [CW-1:0] first_hit_idx,
    output logic          any_hit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam logic [CW-1:0] WMAX = CW'(W);

    state_e        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [W-1:0]  map_q, map_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] first_q, first_d;

    logic [CW-1:0] sel;
    logic [W-1:0]  pat_sh;
    logic [W-1:0]  z_bit;

    // Stream position; idx < len_q <= W so the selected bit is always valid.
    assign sel    = (MSB_FIRST != 0) ? (len_q - CW'(1) - idx_q) : idx_q;
    assign pat_sh = pat_q >> sel;
    assign z_bit  = {{(W-1){1'b0}}, fsm_z} << idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            map_q   <= '0;
            cnt_q   <= '0;
            first_q <= WMAX;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = (len > WMAX) ? WMAX : len;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                map_d   = '0;
                cnt_d   = '0;
                first_d = WMAX;
                idx_d   = '0;
                state_d = (len_q != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                map_d = map_q | z_bit;
                if (fsm_z) begin
                    cnt_d = cnt_q + CW'(1);
                    if (first_q == WMAX) begin
                        first_d = idx_q;
                    end
                end
                idx_d = idx_q + CW'(1);
                if (idx_q == len_q - CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // fsm_rst follows reset combinationally so the FSM resets with us.
    assign fsm_rst       = reset | (state_q == S_CLR);
    assign fsm_x         = (state_q == S_SHIFT) & pat_sh[0];
    assign busy          = (state_q == S_CLR) | (state_q == S_SHIFT);
    assign done          = (state_q == S_DONE);
    assign hit_map       = map_q;
    assign hit_count     = cnt_q;
    assign first_hit_idx = first_q;
    assign any_hit       = (cnt_q != '0);

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// tb_mealy_seq_ctrl: two sequencers (LSB-first and MSB-first), each driving
// an overlapping "101" Mealy detector; results scored from a queue.
module tb_mealy_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start0, start1;
    logic [W-1:0]  pattern;
    logic [CW-1:0] len;

    logic          busy0, done0, rst0, x0, z0, any0;
    logic [W-1:0]  map0;
    logic [CW-1:0] cnt0, first0;
    logic          busy1, done1, rst1, x1, z1, any1;
    logic [W-1:0]  map1;
    logic [CW-1:0] cnt1, first1;

    mealy_seq_ctrl #(.W(W), .MSB_FIRST(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .pattern(pattern), .len(len),
        .busy(busy0), .done(done0),
        .fsm_rst(rst0), .fsm_x(x0), .fsm_z(z0),
        .hit_map(map0), .hit_count(cnt0),
        .first_hit_idx(first0), .any_hit(any0)
    );

    mealy_seq_ctrl #(.W(W), .MSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .pattern(pattern), .len(len),
        .busy(busy1), .done(done1),
        .fsm_rst(rst1), .fsm_x(x1), .fsm_z(z1),
        .hit_map(map1), .hit_count(cnt1),
        .first_hit_idx(first1), .any_hit(any1)
    );

    // Overlapping "101" detector: 0 = idle, 1 = saw 1, 2 = saw 10.
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
        case (s)
            2'd1:    det_next = x ? 2'd1 : 2'd2;
            2'd2:    det_next = x ? 2'd1 : 2'd0;
            default: det_next = x ? 2'd1 : 2'd0;
        endcase
    endfunction

    logic [1:0] d0_q, d1_q;
    always_ff @(posedge clk) begin
        d0_q <= rst0 ? 2'd0 : det_next(d0_q, x0);
        d1_q <= rst1 ? 2'd0 : det_next(d1_q, x1);
    end
    assign z0 = (d0_q == 2'd2) && x0;
    assign z1 = (d1_q == 2'd2) && x1;

    typedef struct {
        logic [W-1:0]  map;
        logic [CW-1:0] cnt;
        logic [CW-1:0] first;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void ref_run(input logic [W-1:0] p, input int l,
                                    input bit msb, output logic [W-1:0] m,
                                    output logic [CW-1:0] c,
                                    output logic [CW-1:0] f);
        logic [1:0] s;
        logic       x;
        int         lc;
        lc = (l > W) ? W : l;
        s = 2'd0; m = '0; c = '0; f = CW'(W);
        for (int j = 0; j < lc; j++) begin
            x = msb ? p[lc-1-j] : p[j];
            if (s == 2'd2 && x) begin
                m[j] = 1'b1;
                c = c + 1'b1;
                if (f == CW'(W)) f = CW'(j);
            end
            s = det_next(s, x);
        end
    endfunction

    // One run: push expectation, pulse start, wait for done, pop and compare.
    // With poke set, start is re-asserted with other data while busy.
    task automatic run_one(input bit sel, input logic [W-1:0] p,
                           input logic [CW-1:0] l, input logic [W-1:0] em,
                           input logic [CW-1:0] ec, input logic [CW-1:0] ef,
                           input bit poke, input string name);
        exp_t e;
        int   k, bc, lc;
        bit   got;
        logic ob, od, oa;
        lc = (l > W) ? W : int'(l);
        e.map = em; e.cnt = ec; e.first = ef; e.lat = lc + 2;
        exp_q.push_back(e);
        @(negedge clk);
        pattern = p; len = l;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        k = 0; bc = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            ob = sel ? busy1 : busy0;
            od = sel ? done1 : done0;
            if (ob) bc++;
            if (od) got = 1'b1;
            if (poke && !got && k >= 2) begin
                start0 = 1'b1; pattern = 8'hFF; len = 4'd8;
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
        end
        start0 = 1'b0; start1 = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (!got || k != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (done=%0b) want %0d", name, k, got, e.lat);
        end
        n_checks++;
        if (bc != e.lat - 1) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, e.lat - 1);
        end
        n_checks++;
        if ((sel ? map1 : map0) !== e.map) begin
            n_fail++;
            $display("FAIL %s hit_map: got %b want %b", name, sel ? map1 : map0, e.map);
        end
        n_checks++;
        if ((sel ? cnt1 : cnt0) !== e.cnt) begin
            n_fail++;
            $display("FAIL %s hit_count: got %0d want %0d", name, sel ? cnt1 : cnt0, e.cnt);
        end
        n_checks++;
        if ((sel ? first1 : first0) !== e.first) begin
            n_fail++;
            $display("FAIL %s first_hit_idx: got %0d want %0d", name, sel ? first1 : first0, e.first);
        end
        oa = sel ? any1 : any0;
        n_checks++;
        if (oa !== (e.cnt != 0)) begin
            n_fail++;
            $display("FAIL %s any_hit: got %0b want %0b", name, oa, e.cnt != 0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        pattern = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy0, done0, x0, map0, cnt0, any0} !== '0) begin
            n_fail++;
            $display("FAIL reset outs: got b%0b d%0b x%0b m%h c%0d a%0b want zeros",
                     busy0, done0, x0, map0, cnt0, any0);
        end
        n_checks++;
        if (first0 !== 4'd8 || first1 !== 4'd8) begin
            n_fail++;
            $display("FAIL reset first_hit_idx: got %0d/%0d want 8", first0, first1);
        end
        n_checks++;
        if (rst0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset fsm_rst: got %0b want 1", rst0);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rst0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: got rst=%0b busy=%0b want 0 0", rst0, busy0);
        end
    endtask

    task automatic test_basic;
        run_one(1'b0, 8'b00101101, 4'd6, 8'b00100100, 4'd2, 4'd2, 1'b0, "basic");
        run_one(1'b0, 8'b00000000, 4'd8, 8'b00000000, 4'd0, 4'd8, 1'b0, "nomatch");
    endtask

    task automatic test_len_bounds;
        run_one(1'b0, 8'hA5, 4'd0, 8'h00, 4'd0, 4'd8, 1'b0, "len0");
        run_one(1'b0, 8'hA5, 4'd12, 8'h84, 4'd2, 4'd2, 1'b0, "len12");
    endtask

    task automatic test_msb_first;
        run_one(1'b1, 8'b00001011, 4'd4, 8'b00000100, 4'd1, 4'd2, 1'b0, "msb");
    endtask

    task automatic test_random;
        logic [W-1:0]  p, m;
        logic [CW-1:0] l, c, f;
        bit            sel;
        for (int i = 0; i < 6; i++) begin
            p   = W'($urandom);
            l   = CW'($urandom_range(0, 10));
            sel = i[0];
            ref_run(p, int'(l), sel, m, c, f);
            run_one(sel, p, l, m, c, f, 1'b0, "random");
        end
    endtask

    task automatic test_reset_shift;
        int nd;
        @(negedge clk);
        pattern = 8'h05; len = 4'd8; start0 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rst0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstshift fsm_rst: got %0b want 1", rst0);
        end
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || x0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstshift idle: got busy=%0b done=%0b x=%0b want 0 0 0",
                     busy0, done0, x0);
        end
        n_checks++;
        if (map0 !== 8'h00 || cnt0 !== 4'd0 || first0 !== 4'd8) begin
            n_fail++;
            $display("FAIL rstshift results: got m=%h c=%0d f=%0d want 00 0 8",
                     map0, cnt0, first0);
        end
        n_checks++;
        if (rst0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstshift fsm_rst held: got %0b want 1", rst0);
        end
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0 || busy0) nd++;
        end
        n_checks++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL rstshift no_done: got %0d active cycles want 0", nd);
        end
    endtask

    task automatic test_start_while_busy;
        int nb;
        run_one(1'b0, 8'h05, 4'd3, 8'h04, 4'd1, 4'd2, 1'b1, "busystart");
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy0 || done0) nb++;
        end
        n_checks++;
        if (nb != 0) begin
            n_fail++;
            $display("FAIL busystart queued: got %0d active cycles want 0", nb);
        end
    endtask

    task automatic test_back_to_back;
        logic d[20], r[20], b[20];
        int   nd, nr, bad;
        @(negedge clk);
        pattern = 8'h05; len = 4'd2; start0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d[i] = done0; r[i] = rst0; b[i] = busy0;
            if (i == 19) start0 = 1'b0;
        end
        nd = 0; nr = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (d[i]) nd++;
            if (r[i]) nr++;
            if (d[i] && i + 2 < 20) begin
                if (r[i+1] || b[i+1] || !r[i+2]) bad++;
            end
        end
        n_checks++;
        if (nd != 4) begin
            n_fail++;
            $display("FAIL b2b done_count: got %0d want 4", nd);
        end
        n_checks++;
        if (nr != 4) begin
            n_fail++;
            $display("FAIL b2b fsm_rst_pulses: got %0d want 4", nr);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b idle_gap: got %0d bad gaps want 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b stop: got busy=%0b want 0", busy0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_bounds();
        test_msb_first();
        test_random();
        test_reset_shift();
        test_start_while_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mealy_seq_ctrl.md
Name: mealy_seq_ctrl

Overview:
Sequencer that drives a single-bit-input, single-bit-output Mealy FSM (ports x, z, clk, reset) as a shared test or scan resource.
- On a start request, it clears the FSM through its reset and streams a parallel pattern into x, one bit per clock.
- It samples the combinational Mealy output z in the same cycle each bit is presented.
- It reports a per-bit hit map, a hit count and the first hit index.
- It sits between a host/register interface and the FSM instance, replacing hand-written stimulus.

Parameters:
- W, 8, maximum pattern length in bits (W >= 2).
- MSB_FIRST, 0, 0 = stream pattern[0] first; 1 = stream pattern[len-1] first.
- CW, $clog2(W+1), width of the length, count and index fields (derived; do not override).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- pattern  input  W  bits to stream; captured on start acceptance.
- len  input  CW  number of bits to stream; captured on start; values > W clamp to W.
- busy  output  1  high in CLR and SHIFT.
- done  output  1  one-cycle pulse in DONE.
- fsm_rst  output  1  reset to the controlled FSM.
- fsm_x  output  1  x input of the controlled FSM.
- fsm_z  input  1  z output of the controlled FSM (combinational Mealy output).
- hit_map  output  W  bit i = sampled z while pattern bit index i was presented.
- hit_count  output  CW  number of set bits in hit_map.
- first_hit_idx  output  CW  index of the first hit; equals W if there was no hit.
- any_hit  output  1  hit_count != 0.

Behaviour:
- Reset values: state = IDLE; busy = 0, done = 0, fsm_x = 0, hit_map = 0, hit_count = 0, first_hit_idx = W, any_hit = 0.
- fsm_rst = reset OR (state == CLR), decoded combinationally, so the FSM is reset whenever this block is reset.
- IDLE: start = 1 at edge t0 captures pattern into pat_reg and min(len, W) into len_reg, then moves to CLR. start while not in IDLE is ignored, with no queuing.
- CLR (exactly 1 cycle, cycle t0+1):
  - fsm_rst = 1, fsm_x = 0.
  - hit_map, hit_count and any_hit clear to 0; first_hit_idx is set to W.
  - idx is set to 0.
  - Next state is SHIFT if len_reg != 0, else DONE.
- SHIFT (len_reg cycles, t0+2 .. t0+len+1):
  - fsm_x = pat_reg[idx], or pat_reg[len_reg-1-idx] when MSB_FIRST = 1.
  - At each edge:
    - hit_map[idx] <= fsm_z.
    - If fsm_z: hit_count increments, and first_hit_idx <= idx if it still equals W.
    - idx increments.
  - Exit to DONE at the edge where idx == len_reg-1.
- DONE (1 cycle): done = 1, busy = 0, fsm_x = 0; next state IDLE.
- Results hold from DONE until the next CLR; they remain valid in IDLE.
- fsm_x is 0 in every state except SHIFT, and changes only on clock edges.
- Bits of hit_map at indices >= len_reg stay 0.
- hit_count cannot exceed W; CW bits suffice and there is no saturation logic.
- Total latency start -> done: len_reg + 2 cycles after the accepting edge, i.e. done is high in cycle t0+len+2.
- start held high continuously: a new run is accepted in each IDLE cycle, so back-to-back runs are separated by one IDLE cycle.
- reset during CLR, SHIFT or DONE: the next state is IDLE, all outputs return to reset values, fsm_rst is asserted, and no done pulse is produced.

Test Plan:
Unless noted, W = 8 and the bench attaches a model of an overlapping "101" Mealy detector (z = 1 when the current x completes 1-0-1).
1. Basic run, MSB_FIRST = 0: pattern = 8'b00101101, len = 6 streams x = 1,0,1,1,0,1.
   -> Required: busy high for 7 cycles, done at t0+8, hit_map = 8'b00100100, hit_count = 2, first_hit_idx = 2, any_hit = 1.
2. No match: pattern = 8'b00000000, len = 8.
   -> Required: hit_map = 0, hit_count = 0, first_hit_idx = 8, any_hit = 0, done at t0+10.
3. len = 0 and len = 12:
   - len = 0 -> CLR then DONE, done at t0+2, no SHIFT cycles.
   - len = 12 -> clamped to 8, done at t0+10.
4. MSB_FIRST = 1: pattern = 8'b00001011, len = 4 streams x = 1,0,1,1.
   -> Required: hit_map = 8'b00000100, first_hit_idx = 2, hit_count = 1.
5. Reset in SHIFT: assert reset at the 3rd SHIFT cycle.
   -> Required: next cycle is IDLE, busy = 0, no done pulse, hit_map = 0, fsm_rst high while reset is high.
6. start during busy is ignored; start held high gives back-to-back runs with exactly one IDLE cycle between done and the next CLR, and fsm_rst pulses once per run.
